mix_column_sched: RTL and testbench
===================================

// Module: mix_column_sched
// PURPOSE
//  Sequences a small pool of GF(2^8) multipliers (poly 0x11B) to compute one
//  AES MixColumns / InvMixColumns column transform per transaction.
//  Sits between the round datapath and the shared combinational byte
//  multiplier. Trades area for latency: 16 byte products spread over
//  16/MUL_PER_CYC cycles. Input and output use valid/ready handshakes.
// PARAMETERS
//  MUL_PER_CYC  1  multiplier instances used per cycle; legal 1, 2, 4
//                  (other values: elaboration $error)
// PORTS
//  clk_i     in   1   clock
//  reset_i   in   1   synchronous, active-high reset
//  v_i       in   1   input column valid
//  ready_o   out  1   block can accept a column this cycle
//  inv_i     in   1   1 = InvMixColumns, 0 = MixColumns; sampled with column
//  col_i     in   32  column a0..a3, a0 = col_i[31:24], a3 = col_i[7:0]
//  v_o       out  1   result valid
//  ready_i   in   1   consumer accepts result
//  col_o     out  32  result b0..b3, same byte order as col_i
// BEHAVIOUR
//  Math:
//  - b_r = XOR over c of M[r][c]*a_c, with M[r][c] = K[(c-r) mod 4].
//  - inv_i=1: K = {0e,0b,0d,09}. inv_i=0: K = {02,03,01,01}.
//  - All products go through the multiplier instances, including coeff 01.
//  - Accumulate by XOR into four 8-bit registers. No carries.
//  Schedule:
//  - 4-bit step counter s, 0..15: r = s[3:2], c = s[1:0].
//  - Per cycle, lanes k = 0..MUL_PER_CYC-1 compute step s+k.
//  - s advances by MUL_PER_CYC each cycle.
//  - N = 16/MUL_PER_CYC busy cycles.
//  FSM IDLE / BUSY / DONE:
//  - IDLE: ready_o = 1.
//    - On v_i & ready_o: latch col_i and inv_i, clear acc, s = 0, go to BUSY.
//  - BUSY: ready_o = 0, v_o = 0. One schedule slot per cycle.
//    - After the slot containing s = 15: go to DONE.
//    - col_o is loaded from acc on that same transition.
//  - DONE: v_o = 1. col_o is stable until v_o & ready_i.
//    - On v_o & ready_i: go to IDLE.
//    - ready_o = 0 in DONE; there is no accept/drain overlap.
//  Latency and throughput:
//  - Accept on edge T. BUSY occupies cycles T+1..T+N. v_o first high in cycle T+N+1.
//  - Peak throughput is 1 column per N+2 cycles (consumer ready_i held high).
//  Handshake rules:
//  - v_i while ready_o = 0 is ignored; it is not queued.
//  - col_i and inv_i are don't-care except on the accept cycle.
//  - Input changes during BUSY or DONE never affect the result.
//  - ready_i while v_o = 0 has no effect.
//  Reset (sync, high):
//  - Next state IDLE. v_o = 0, col_o = 32'h0, acc = 0, s = 0.
//  - ready_o = 0 while reset_i = 1, then 1 in the first cycle after release.
//  - Reset mid-BUSY or in DONE aborts the transaction; the partial result is dropped.
//  - Transfer on the reset cycle: no accept and no result handshake occurs.
// TESTING
//  1. inv=0, col db135345 -> col_o 8e4da1bc.
//     v_o rises exactly 17 cycles after accept (MUL_PER_CYC=1).
//  2. inv=1, col 8e4da1bc -> db135345.
//     Repeat with MUL_PER_CYC=2 (v_o at +9) and MUL_PER_CYC=4 (v_o at +5).
//  3. inv=0: d4bf5d30 -> 046681e5, f20a225c -> 9fdc589d.
//     inv=1: 01010101 -> 01010101, c6c6c6c6 -> c6c6c6c6.
//  4. Backpressure: hold ready_i = 0 for 10 cycles in DONE.
//     - col_o stable, v_o held, ready_o = 0.
//     - Toggle col_i/inv_i during BUSY: no effect on the result.
//  5. Back-to-back: 8 random columns, v_i and ready_i held high.
//     - Results match the software model in order, one per 18 cycles (MUL_PER_CYC=1).
//  6. Reset at BUSY s = 7, and again in DONE.
//     - Next cycle: v_o = 0, col_o = 0, ready_o = 1 after release.
//     - Next column computes correctly.

Source files
------------

// File: rtl/mix_column_sched_if.sv
// rtl/mix_column_sched_if.sv - column in/out valid/ready bundle for mix_column_sched
interface mix_column_sched_if;
  logic        v_i;
  logic        ready_o;
  logic        inv_i;
  logic [31:0] col_i;
  logic        v_o;
  logic        ready_i;
  logic [31:0] col_o;

  // producer/consumer side driving the block
  modport master (
    output v_i, inv_i, col_i, ready_i,
    input  ready_o, v_o, col_o
  );

  // the scheduler itself
  modport slave (
    input  v_i, inv_i, col_i, ready_i,
    output ready_o, v_o, col_o
  );
endinterface

// File: rtl/mix_column_sched.sv
// rtl/mix_column_sched.sv - time-multiplexed GF(2^8) MixColumns/InvMixColumns column engine
module mix_column_sched #(
  parameter int MUL_PER_CYC = 1
) (
  input logic               clk_i,
  input logic               reset_i,
  mix_column_sched_if.slave port
);

  if (MUL_PER_CYC != 1 && MUL_PER_CYC != 2 && MUL_PER_CYC != 4) begin : g_bad_mul
    $error("mix_column_sched: MUL_PER_CYC must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // s value of the final slot, the one whose last lane computes step 15
  localparam logic [3:0] LAST_S = 4'(16 - MUL_PER_CYC);
  localparam logic [3:0] S_INC  = 4'(MUL_PER_CYC);

  state_t          state_q, state_d;
  logic [3:0]      s_q;
  logic            inv_q;
  logic [3:0][7:0] col_q;   // col_q[3] = a0 ... col_q[0] = a3
  logic [3:0][7:0] acc_q;   // acc_q[3] = b0 ... acc_q[0] = b3
  logic [3:0][7:0] acc_d;
  logic [31:0]     col_o_q;
  logic            accept;
  logic            last_slot;

  // GF(2^8) product modulo x^8+x^4+x^3+x+1; one copy per lane is one multiplier
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // circulant row coefficient K[(c - r) mod 4]
  function automatic logic [7:0] coeff(input logic inv, input logic [1:0] d);
    logic [7:0] k;
    k = 8'h01;
    case (d)
      2'd0: k = inv ? 8'h0e : 8'h02;
      2'd1: k = inv ? 8'h0b : 8'h03;
      2'd2: k = inv ? 8'h0d : 8'h01;
      2'd3: k = inv ? 8'h09 : 8'h01;
      default: k = 8'h01;
    endcase
    return k;
  endfunction

  assign port.ready_o = (state_q == IDLE) && !reset_i;
  assign port.v_o     = (state_q == DONE) && !reset_i;
  assign port.col_o   = col_o_q;

  assign accept    = (state_q == IDLE) && port.v_i;
  assign last_slot = (state_q == BUSY) && (s_q == LAST_S);

  // lanes k compute step s+k; all lanes of one slot share the same row r
  always_comb begin : lane_acc
    logic [3:0] step;
    logic [1:0] r;
    logic [1:0] c;
    step  = 4'd0;
    r     = 2'd0;
    c     = 2'd0;
    acc_d = acc_q;
    for (int k = 0; k < MUL_PER_CYC; k++) begin
      step = s_q + 4'(k);
      r    = step[3:2];
      c    = step[1:0];
      acc_d[~r] = acc_d[~r] ^ gf_mul(coeff(inv_q, c - r), col_q[~c]);
    end
  end

  // state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last_slot) state_d = DONE;
      DONE:    if (port.ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // column capture, accumulation and result register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      col_q   <= '0;
      inv_q   <= 1'b0;
      acc_q   <= '0;
      s_q     <= 4'd0;
      col_o_q <= 32'h0;
    end else begin
      if (accept) begin
        col_q <= port.col_i;
        inv_q <= port.inv_i;
        acc_q <= '0;
        s_q   <= 4'd0;
      end
      if (state_q == BUSY) begin
        acc_q <= acc_d;
        s_q   <= s_q + S_INC;
        if (last_slot) col_o_q <= acc_d;
      end
    end
  end

endmodule

// File: tb/tb_mix_column_sched.sv
// tb/tb_mix_column_sched.sv - directed checks of mix_column_sched at MUL_PER_CYC 1, 2 and 4
module tb_mix_column_sched;
  logic        clk = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic        inv_i;
  logic [31:0] col_i;
  logic        ready_i;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mix_column_sched_if if1 ();
  mix_column_sched_if if2 ();
  mix_column_sched_if if4 ();

  assign if1.v_i = v_i;  assign if1.inv_i = inv_i;  assign if1.col_i = col_i;  assign if1.ready_i = ready_i;
  assign if2.v_i = v_i;  assign if2.inv_i = inv_i;  assign if2.col_i = col_i;  assign if2.ready_i = ready_i;
  assign if4.v_i = v_i;  assign if4.inv_i = inv_i;  assign if4.col_i = col_i;  assign if4.ready_i = ready_i;

  mix_column_sched #(.MUL_PER_CYC(1)) u_dut1 (.clk_i(clk), .reset_i(reset_i), .port(if1.slave));
  mix_column_sched #(.MUL_PER_CYC(2)) u_dut2 (.clk_i(clk), .reset_i(reset_i), .port(if2.slave));
  mix_column_sched #(.MUL_PER_CYC(4)) u_dut4 (.clk_i(clk), .reset_i(reset_i), .port(if4.slave));

  logic [2:0]  ready_all;
  logic [2:0]  v_all;
  logic [31:0] col_all [3];
  assign ready_all  = {if4.ready_o, if2.ready_o, if1.ready_o};
  assign v_all      = {if4.v_o, if2.v_o, if1.v_o};
  assign col_all[0] = if1.col_o;
  assign col_all[1] = if2.col_o;
  assign col_all[2] = if4.col_o;

  typedef struct {
    logic        inv;
    logic [31:0] col;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // reference transform built from xtime chains
  function automatic logic [31:0] model(input logic inv, input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m1 [4], m2 [4], m3 [4], m9 [4], mb [4], md [4], me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m1[i] = a[i];
      m2[i] = x2;
      m3[i] = x2 ^ a[i];
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    if (!inv)
      return {m2[0] ^ m3[1] ^ m1[2] ^ m1[3],
              m1[0] ^ m2[1] ^ m3[2] ^ m1[3],
              m1[0] ^ m1[1] ^ m2[2] ^ m3[3],
              m3[0] ^ m1[1] ^ m1[2] ^ m2[3]};
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 40 && ready_all != 3'b111; i++) @(negedge clk);
    chk("idle_wait", {29'd0, ready_all}, 32'd7);
  endtask

  // one column into all three instances; checks latency and result of each
  task automatic run_vec(input string name, input logic inv, input logic [31:0] col, input logic [31:0] req);
    int          lat [3];
    logic [31:0] got [3];
    bit          seen [3];
    int          exp_lat [3];
    exp_lat = '{17, 9, 5};
    for (int j = 0; j < 3; j++) begin lat[j] = -1; got[j] = 32'hx; seen[j] = 1'b0; end
    ready_i = 1'b1;
    wait_idle();
    v_i = 1'b1; inv_i = inv; col_i = col;
    @(negedge clk);
    v_i = 1'b0; inv_i = ~inv; col_i = ~col;
    for (int cnt = 1; cnt <= 30; cnt++) begin
      for (int j = 0; j < 3; j++)
        if (v_all[j] && !seen[j]) begin seen[j] = 1'b1; lat[j] = cnt; got[j] = col_all[j]; end
      @(negedge clk);
    end
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s_lat_m%0d", name, 1 << j), 32'(lat[j]), 32'(exp_lat[j]));
      chk($sformatf("%s_col_m%0d", name, 1 << j), got[j], req);
    end
  endtask

  vec_t        vecs [6];
  logic [31:0] bb_col [8];
  logic        bb_inv [8];
  int          cnt;

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 32'hdb135345, 32'h8e4da1bc};
    vecs[1] = '{1'b1, 32'h8e4da1bc, 32'hdb135345};
    vecs[2] = '{1'b0, 32'hd4bf5d30, 32'h046681e5};
    vecs[3] = '{1'b0, 32'hf20a225c, 32'h9fdc589d};
    vecs[4] = '{1'b1, 32'h01010101, 32'h01010101};
    vecs[5] = '{1'b1, 32'hc6c6c6c6, 32'hc6c6c6c6};

    reset_i = 1'b1; v_i = 1'b0; inv_i = 1'b0; col_i = 32'h0; ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready_low", {29'd0, ready_all}, 32'd0);
    reset_i = 1'b0;
    #1;
    chk("rst_ready_high", {29'd0, ready_all}, 32'd7);
    chk("rst_v_o", {29'd0, v_all}, 32'd0);
    chk("rst_col_o", if1.col_o | if2.col_o | if4.col_o, 32'h0);
    @(negedge clk);

    // table vectors across all three multiplier widths
    for (int i = 0; i < 6; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].inv, vecs[i].col, vecs[i].exp);

    // backpressure in DONE; input churn and stray v_i during BUSY
    ready_i = 1'b0;
    wait_idle();
    v_i = 1'b1; inv_i = 1'b0; col_i = 32'hdb135345;
    @(negedge clk);
    cnt = 1;
    while (!if1.v_o && cnt < 30) begin
      col_i = $urandom; inv_i = ~inv_i; v_i = 1'b1;
      @(negedge clk);
      cnt++;
    end
    v_i = 1'b0;
    chk("bp_latency", 32'(cnt), 32'd17);
    for (int i = 0; i < 10; i++) begin
      chk("bp_col_o", if1.col_o, 32'h8e4da1bc);
      chk("bp_v_o", {31'd0, if1.v_o}, 32'd1);
      chk("bp_ready_o", {31'd0, if1.ready_o}, 32'd0);
      @(negedge clk);
    end
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_v_o", {31'd0, if1.v_o}, 32'd0);
    chk("bp_release_ready_o", {31'd0, if1.ready_o}, 32'd1);

    // back-to-back stream, one result per 18 cycles
    for (int i = 0; i < 8; i++) begin
      bb_col[i] = $urandom;
      bb_inv[i] = 1'($urandom_range(0, 1));
    end
    wait_idle();
    begin
      int in_idx, out_idx, prev;
      in_idx = 0; out_idx = 0; prev = -1;
      for (int cyc = 0; cyc < 250 && out_idx < 8; cyc++) begin
        if (if1.v_o) begin
          chk($sformatf("bb_col%0d", out_idx), if1.col_o, model(bb_inv[out_idx], bb_col[out_idx]));
          if (prev >= 0) chk($sformatf("bb_gap%0d", out_idx), 32'(cyc - prev), 32'd18);
          prev = cyc;
          out_idx++;
        end
        if (if1.ready_o) begin
          if (in_idx < 8) begin
            v_i = 1'b1; col_i = bb_col[in_idx]; inv_i = bb_inv[in_idx];
            in_idx++;
          end else v_i = 1'b0;
        end
        @(negedge clk);
      end
      v_i = 1'b0;
      chk("bb_count", 32'(out_idx), 32'd8);
    end

    // reset in BUSY at s = 7
    wait_idle();
    v_i = 1'b1; inv_i = 1'b0; col_i = 32'hd4bf5d30;
    @(negedge clk);
    v_i = 1'b0;
    repeat (7) @(negedge clk);
    reset_i = 1'b1;
    #1;
    chk("rbusy_ready_during", {31'd0, if1.ready_o}, 32'd0);
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("rbusy_v_o", {31'd0, if1.v_o}, 32'd0);
    chk("rbusy_col_o", if1.col_o, 32'h0);
    chk("rbusy_ready_o", {31'd0, if1.ready_o}, 32'd1);
    @(negedge clk);
    run_vec("after_rbusy", 1'b0, 32'hf20a225c, 32'h9fdc589d);

    // reset while holding a result in DONE
    ready_i = 1'b0;
    wait_idle();
    v_i = 1'b1; inv_i = 1'b0; col_i = 32'hdb135345;
    @(negedge clk);
    v_i = 1'b0;
    for (int i = 0; i < 30 && !if1.v_o; i++) @(negedge clk);
    chk("rdone_reached", {31'd0, if1.v_o}, 32'd1);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("rdone_v_o", {31'd0, if1.v_o}, 32'd0);
    chk("rdone_col_o", if1.col_o, 32'h0);
    chk("rdone_ready_o", {31'd0, if1.ready_o}, 32'd1);
    @(negedge clk);
    run_vec("after_rdone", 1'b1, 32'h8e4da1bc, 32'hdb135345);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
